ksw_band_row_ctrl: RTL

- Sequential row controller for the banded extension DP (ksw2 extd2-style, dual affine gap).
- Steps the anti-diagonal index r from 0 to TLEN+QLEN-2. For each row it computes the clamped band [st0,en0] and the LANES-aligned band [st,en].
- Produces the left-boundary seeds (x1, x21, v1) and a boundary-init write for the y/y2/u arrays.
- Hands each row to the DP core over a valid/ready handshake.
- Successor of the combinational band calculator: parametrised lanes, scores and lengths; adds query-length clamping, sequencing, handshake, seed tracking and z-drop abort.

---
 rtl/ksw_band_row_ctrl_if.sv | 43 ++++
 rtl/ksw_band_row_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksw_band_row_ctrl_if.sv
// ----------------------------------------------------------------------------
// ksw_band_row_ctrl_if
// Row descriptor channel between the band row controller and the DP core.
//   master (controller): drives row_valid and every row/seed/init field,
//                        samples row_ready.
//   slave  (DP core)   : samples the descriptor, drives row_ready.
// A row transfers on the cycle where row_valid && row_ready.
// init_we is only ever high on that transfer cycle.
// ----------------------------------------------------------------------------
interface ksw_band_row_ctrl_if #(
  parameter int LANE_W = 4
);
  logic                row_valid;
  logic                row_ready;
  logic [15:0]         row_r;
  logic [15:0]         st0;
  logic [15:0]         en0;
  logic [15:0]         st;
  logic [15:0]         en;
  logic                row_empty;
  logic                seed_from_prev;
  logic signed [7:0]   x1;
  logic signed [7:0]   x21;
  logic signed [7:0]   v1;
  logic                init_we;
  logic [15:0]         init_addr;
  logic [LANE_W-1:0]   init_lane;
  logic signed [7:0]   y_init;
  logic signed [7:0]   y2_init;
  logic signed [7:0]   u_init;

  modport master (
    output row_valid, row_r, st0, en0, st, en, row_empty, seed_from_prev,
           x1, x21, v1, init_we, init_addr, init_lane, y_init, y2_init, u_init,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_r, st0, en0, st, en, row_empty, seed_from_prev,
           x1, x21, v1, init_we, init_addr, init_lane, y_init, y2_init, u_init,
    output row_ready
  );
endinterface

// File: rtl/ksw_band_row_ctrl.sv
// ----------------------------------------------------------------------------
// ksw_band_row_ctrl
// Sequential row controller for a banded dual-affine extension DP.
// It walks the anti-diagonal index r from 0 to TLEN+QLEN-2. For each row it
// computes the clamped band [st0,en0], the lane-aligned band [st,en], the
// left-boundary seeds and the y/y2/u boundary-init write. It then offers the
// row to the DP core over row_if.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_start       begin a sweep (only looked at in IDLE)
//   i_zdrop       abort request, only looked at on a row transfer
//   o_busy        controller is not IDLE
//   o_done        one-cycle pulse when a sweep finishes or aborts
//   row_if        row descriptor channel (master side)
// ----------------------------------------------------------------------------
module ksw_band_row_ctrl #(
  parameter int TLEN       = 2007,
  parameter int QLEN       = 5000,
  parameter int WL         = 751,
  parameter int WR         = 751,
  parameter int LANES      = 16,
  parameter int Q          = 4,
  parameter int E          = 2,
  parameter int Q2         = 24,
  parameter int E2         = 1,
  parameter int LONG_THRES = 19,
  parameter int LONG_DIFF  = -2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_zdrop,
  output logic o_busy,
  output logic o_done,
  ksw_band_row_ctrl_if.master row_if
);

  localparam int LW = $clog2(LANES);

  localparam logic [15:0]        LAST_R    = 16'(TLEN + QLEN - 2);
  localparam logic [16:0]        INIT_LIM  = 17'(((TLEN + LANES - 1) / LANES) * LANES);
  localparam logic [15:0]        LANE_MASK = 16'(LANES - 1);
  localparam logic [15:0]        LONG_R    = 16'(LONG_THRES);
  localparam logic signed [17:0] QLEN_M1   = 18'(QLEN - 1);
  localparam logic signed [17:0] WR_M1     = 18'(WR - 1);
  localparam logic signed [17:0] WL_S      = 18'(WL);
  localparam logic signed [17:0] TLEN_M1   = 18'(TLEN - 1);

  localparam logic [7:0] SEED_QE   = 8'(-(Q + E));
  localparam logic [7:0] SEED_Q2E2 = 8'(-(Q2 + E2));
  localparam logic [7:0] SEED_E    = 8'(-E);
  localparam logic [7:0] SEED_E2   = 8'(-E2);
  localparam logic [7:0] SEED_LD   = 8'(LONG_DIFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Left-boundary v seed on the st==0 column; the same value initialises u at r.
  function automatic logic [7:0] v1_at(input logic [15:0] r);
    logic [7:0] v;
    if (r == 16'd0) begin
      v = SEED_QE;
    end else if (r < LONG_R) begin
      v = SEED_E;
    end else if (r == LONG_R) begin
      v = SEED_LD;
    end else begin
      v = SEED_E2;
    end
    return v;
  endfunction

  // Floors negatives to 0 and saturates anything past 16 bits.
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    logic [15:0] s;
    if (v[17]) begin
      s = 16'd0;
    end else if (v[16]) begin
      s = 16'hFFFF;
    end else begin
      s = v[15:0];
    end
    return s;
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;
  logic   w_load;
  logic   w_hs;

  logic [15:0] r_row;
  logic [15:0] r_last_st;
  logic [15:0] r_last_en;
  logic        r_busy;
  logic        r_done;
  logic        r_row_valid;
  logic [15:0] r_st0;
  logic [15:0] r_en0;
  logic [15:0] r_st;
  logic [15:0] r_en;
  logic        r_row_empty;
  logic        r_seed_prev;
  logic [7:0]  r_x1;
  logic [7:0]  r_x21;
  logic [7:0]  r_v1;
  logic        r_init_ok;
  logic [15:0] r_init_addr;
  logic [LW-1:0] r_init_lane;
  logic [7:0]  r_y_init;
  logic [7:0]  r_y2_init;
  logic [7:0]  r_u_init;

  logic signed [17:0] w_r18;
  logic signed [17:0] w_lo_q;
  logic signed [17:0] w_lo_w;
  logic signed [17:0] w_lo_max;
  logic signed [17:0] w_hi_w;
  logic signed [17:0] w_hi_tr;
  logic signed [17:0] w_hi_min;
  logic [15:0] w_st0;
  logic [15:0] w_en0;
  logic [15:0] w_st;
  logic [15:0] w_en;
  logic [15:0] w_st_m1;
  logic        w_prev;
  logic [7:0]  w_x1;
  logic [7:0]  w_x21;
  logic [7:0]  w_v1;
  logic        w_init_ok;

  // Band and seed computation for the current row index.
  always_comb begin
    w_r18    = $signed({2'b00, r_row});
    w_lo_q   = w_r18 - QLEN_M1;
    w_lo_w   = (w_r18 - WR_M1) >>> 1;
    w_lo_max = (w_lo_q > w_lo_w) ? w_lo_q : w_lo_w;
    w_hi_w   = (w_r18 + WL_S) >>> 1;
    w_hi_tr  = (TLEN_M1 < w_r18) ? TLEN_M1 : w_r18;
    w_hi_min = (w_hi_w < w_hi_tr) ? w_hi_w : w_hi_tr;
    w_st0    = sat16(w_lo_max);
    w_en0    = sat16(w_hi_min);
    w_st     = w_st0 & ~LANE_MASK;
    // Round en0 up to the last cell of its lane word.
    w_en     = ((w_en0 + 16'(LANES)) & ~LANE_MASK) - 16'd1;
    w_st_m1  = w_st - 16'd1;
    // Row 0 has no predecessor, so last_st/last_en are ignored there.
    w_prev   = (w_st != 16'd0) && (r_row != 16'd0) &&
               (r_last_st <= w_st_m1) && (w_st_m1 <= r_last_en);
    if (w_st == 16'd0) begin
      w_x1  = SEED_QE;
      w_x21 = SEED_Q2E2;
      w_v1  = v1_at(r_row);
    end else if (w_prev) begin
      // Core reads x/x2/v at st-1 from the previous row; seeds unused.
      w_x1  = 8'd0;
      w_x21 = 8'd0;
      w_v1  = 8'd0;
    end else begin
      w_x1  = SEED_QE;
      w_x21 = SEED_Q2E2;
      w_v1  = SEED_QE;
    end
    w_init_ok = (w_en >= r_row) && ({1'b0, r_row} < INIT_LIM);
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_load      = 1'b1;
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (row_if.row_ready) begin
          w_hs = 1'b1;
          if ((r_row == LAST_R) || i_zdrop) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and state-decoded output flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_row_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_row_valid <= (w_state_nxt == ST_ISSUE);
    end
  end

  // Row index, previous-row band and the registered row descriptor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row       <= 16'd0;
      r_last_st   <= 16'd0;
      r_last_en   <= 16'd0;
      r_st0       <= 16'd0;
      r_en0       <= 16'd0;
      r_st        <= 16'd0;
      r_en        <= 16'd0;
      r_row_empty <= 1'b0;
      r_seed_prev <= 1'b0;
      r_x1        <= 8'd0;
      r_x21       <= 8'd0;
      r_v1        <= 8'd0;
      r_init_ok   <= 1'b0;
      r_init_addr <= 16'd0;
      r_init_lane <= '0;
      r_y_init    <= 8'd0;
      r_y2_init   <= 8'd0;
      r_u_init    <= 8'd0;
    end else begin
      if (w_start) begin
        r_row     <= 16'd0;
        r_last_st <= 16'd0;
        r_last_en <= 16'd0;
      end else if (w_hs) begin
        r_last_st <= r_st;
        r_last_en <= r_en;
        if (w_state_nxt == ST_CALC) begin
          r_row <= r_row + 16'd1;
        end
      end
      if (w_load) begin
        r_st0       <= w_st0;
        r_en0       <= w_en0;
        r_st        <= w_st;
        r_en        <= w_en;
        r_row_empty <= (w_st0 > w_en0);
        r_seed_prev <= w_prev;
        r_x1        <= w_x1;
        r_x21       <= w_x21;
        r_v1        <= w_v1;
        r_init_ok   <= w_init_ok;
        r_init_addr <= r_row >> LW;
        r_init_lane <= r_row[LW-1:0];
        r_y_init    <= SEED_QE;
        r_y2_init   <= SEED_Q2E2;
        r_u_init    <= v1_at(r_row);
      end
    end
  end

  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign row_if.row_valid      = r_row_valid;
  assign row_if.row_r          = r_row;
  assign row_if.st0            = r_st0;
  assign row_if.en0            = r_en0;
  assign row_if.st             = r_st;
  assign row_if.en             = r_en;
  assign row_if.row_empty      = r_row_empty;
  assign row_if.seed_from_prev = r_seed_prev;
  assign row_if.x1             = r_x1;
  assign row_if.x21            = r_x21;
  assign row_if.v1             = r_v1;
  // The write strobe follows the transfer itself, so it needs row_ready.
  assign row_if.init_we        = r_row_valid & row_if.row_ready & r_init_ok;
  assign row_if.init_addr      = r_init_addr;
  assign row_if.init_lane      = r_init_lane;
  assign row_if.y_init         = r_y_init;
  assign row_if.y2_init        = r_y2_init;
  assign row_if.u_init         = r_u_init;

endmodule
